// File: rtl/mul_pkg.sv
// Shared types for the iterative 33x33 multiply unit and its requester-side
// controller. The unit imports mul_op_e from here as well.
package mul_pkg;

  localparam int unsigned MUL_OP_W = 2;

  typedef enum logic [MUL_OP_W-1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [2:0] {
    CTRL_IDLE,
    CTRL_ISSUE,
    CTRL_WAIT,
    CTRL_DONE,
    CTRL_DRAIN
  } mul_ctrl_state_e;

  // A product is trivially zero when either operand is zero; W-variants only
  // look at the low words.
  function automatic logic mul_operand_zero(input logic        word,
                                            input logic [63:0] a,
                                            input logic [63:0] b);
    if (word) begin
      return (a[31:0] == 32'd0) || (b[31:0] == 32'd0);
    end
    return (a == 64'd0) || (b == 64'd0);
  endfunction

endpackage

// File: rtl/mul_req_ctrl.sv
// Requester-side controller for the iterative multiply unit. Accepts one
// micro-op at a time from issue, forwards it to the unit, captures the
// single-cycle result pulse and holds the tagged result for writeback.
// Flush kills any op not yet written back; a request already handshaken with
// the unit is drained because the unit cannot be killed.
// Optional feature: define MUL_ZERO_BYPASS_EN to complete ops with a zero
// operand directly from IDLE without using the unit.
module mul_req_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned TAG_W = 6,
  parameter int unsigned RD_W  = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             iss_valid_i,
  output logic             iss_ready_o,
  input  mul_op_e          iss_op_i,
  input  logic             iss_word_i,
  input  logic [63:0]      iss_a_i,
  input  logic [63:0]      iss_b_i,
  input  logic [TAG_W-1:0] iss_tag_i,
  input  logic [RD_W-1:0]  iss_rd_i,
  output logic             mul_req_valid_o,
  input  logic             mul_req_ready_i,
  output mul_op_e          mul_op_o,
  output logic             mul_word_o,
  output logic [63:0]      mul_a_o,
  output logic [63:0]      mul_b_o,
  input  logic             mul_resp_valid_i,
  input  logic [63:0]      mul_resp_value_i,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [TAG_W-1:0] wb_tag_o,
  output logic [RD_W-1:0]  wb_rd_o,
  output logic [63:0]      wb_value_o
);

  mul_ctrl_state_e  state_q, state_d;
  mul_op_e          op_q;
  logic             word_q;
  logic [63:0]      a_q, b_q;
  logic [TAG_W-1:0] tag_q;
  logic [RD_W-1:0]  rd_q;
  logic [63:0]      value_q;

  logic load_iss;
  logic load_resp;
  logic clr_value;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CTRL_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, handshake outputs and latch enables; flush outranks all events.
  always_comb begin
    state_d         = state_q;
    load_iss        = 1'b0;
    load_resp       = 1'b0;
    clr_value       = 1'b0;
    iss_ready_o     = 1'b0;
    mul_req_valid_o = 1'b0;
    wb_valid_o      = 1'b0;
    unique case (state_q)
      CTRL_IDLE: begin
        iss_ready_o = 1'b1;
        if (iss_valid_i && !flush_i) begin
          load_iss = 1'b1;
`ifdef MUL_ZERO_BYPASS_EN
          if (mul_operand_zero(iss_word_i, iss_a_i, iss_b_i)) begin
            clr_value = 1'b1;
            state_d   = CTRL_DONE;
          end else begin
            state_d = CTRL_ISSUE;
          end
`else
          state_d = CTRL_ISSUE;
`endif
        end
      end
      CTRL_ISSUE: begin
        // req_valid is masked during flush so a same-cycle ready from the unit
        // cannot start an op whose result nobody would wait for.
        if (flush_i) begin
          state_d = CTRL_IDLE;
        end else begin
          mul_req_valid_o = 1'b1;
          if (mul_req_ready_i) begin
            state_d = CTRL_WAIT;
          end
        end
      end
      CTRL_WAIT: begin
        if (flush_i) begin
          state_d = mul_resp_valid_i ? CTRL_IDLE : CTRL_DRAIN;
        end else if (mul_resp_valid_i) begin
          load_resp = 1'b1;
          state_d   = CTRL_DONE;
        end
      end
      CTRL_DONE: begin
        wb_valid_o = 1'b1;
        if (flush_i || wb_ready_i) begin
          state_d = CTRL_IDLE;
        end
      end
      CTRL_DRAIN: begin
        if (mul_resp_valid_i) begin
          state_d = CTRL_IDLE;
        end
      end
      default: state_d = CTRL_IDLE;
    endcase
  end

  // Operand/metadata latches and the result holding register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q    <= MUL_OP_MUL;
      word_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      rd_q    <= '0;
      value_q <= '0;
    end else begin
      if (load_iss) begin
        op_q   <= iss_op_i;
        word_q <= iss_word_i;
        a_q    <= iss_a_i;
        b_q    <= iss_b_i;
        tag_q  <= iss_tag_i;
        rd_q   <= iss_rd_i;
      end
      if (clr_value) begin
        value_q <= '0;
      end else if (load_resp) begin
        value_q <= mul_resp_value_i;
      end
    end
  end

  assign mul_op_o   = op_q;
  assign mul_word_o = word_q;
  assign mul_a_o    = a_q;
  assign mul_b_o    = b_q;
  assign wb_tag_o   = tag_q;
  assign wb_rd_o    = rd_q;
  assign wb_value_o = value_q;

  // A result pulse is only legal while an op is outstanding at the unit.
  mul_resp_outside_wait_a: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
      mul_resp_valid_i |-> (state_q inside {CTRL_WAIT, CTRL_DRAIN}));

endmodule

// File: tb/tb_mul_req_ctrl.sv
module tb_mul_req_ctrl;
  import mul_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        iss_valid = 1'b0;
  logic        iss_ready;
  mul_op_e     iss_op = MUL_OP_MUL;
  logic        iss_word = 1'b0;
  logic [63:0] iss_a = '0, iss_b = '0;
  logic [5:0]  iss_tag = '0;
  logic [4:0]  iss_rd = '0;
  logic        mul_req_valid;
  logic        mul_req_ready = 1'b0;
  mul_op_e     mul_op;
  logic        mul_word;
  logic [63:0] mul_a, mul_b;
  logic        mul_resp_valid = 1'b0;
  logic [63:0] mul_resp_value = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [5:0]  wb_tag;
  logic [4:0]  wb_rd;
  logic [63:0] wb_value;

  always #5 clk = ~clk;

  mul_req_ctrl #(.TAG_W(6), .RD_W(5)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .iss_valid_i(iss_valid), .iss_ready_o(iss_ready), .iss_op_i(iss_op),
    .iss_word_i(iss_word), .iss_a_i(iss_a), .iss_b_i(iss_b),
    .iss_tag_i(iss_tag), .iss_rd_i(iss_rd),
    .mul_req_valid_o(mul_req_valid), .mul_req_ready_i(mul_req_ready),
    .mul_op_o(mul_op), .mul_word_o(mul_word), .mul_a_o(mul_a), .mul_b_o(mul_b),
    .mul_resp_valid_i(mul_resp_valid), .mul_resp_value_i(mul_resp_value),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_tag_o(wb_tag),
    .wb_rd_o(wb_rd), .wb_value_o(wb_value)
  );

  typedef struct {
    logic [5:0]  tag;
    logic [4:0]  rd;
    logic [63:0] value;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;
  int unsigned last_pop = 0;
  int unsigned hold_left = 0;
  int unsigned stall_left = 0;
  logic        prev_wbv = 1'b0;
  logic        req_seen = 1'b0;

  mul_op_e     cur_op = MUL_OP_MUL;
  logic        cur_word = 1'b0;
  logic [63:0] cur_a = '0, cur_b = '0;

  logic        u_busy = 1'b0;
  int unsigned u_due = 0;
  logic [63:0] u_val = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // Reference behaviour of the multiply unit.
  function automatic logic [63:0] umodel(input mul_op_e op, input logic w,
                                         input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic [63:0]  t;
    if (w) begin
      t = {32'd0, a[31:0]} * {32'd0, b[31:0]};
      return {{32{t[31]}}, t[31:0]};
    end
    case (op)
      MUL_OP_MUL:    p = {64'd0, a} * {64'd0, b};
      MUL_OP_MULH:   p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
      MUL_OP_MULHSU: p = {{64{a[63]}}, a} * {64'd0, b};
      default:       p = {64'd0, a} * {64'd0, b};
    endcase
    return (op == MUL_OP_MUL) ? p[63:0] : p[127:64];
  endfunction

  function automatic int unsigned ulat(input mul_op_e op, input logic w);
    if (w) return 2;
    return (op == MUL_OP_MUL) ? 4 : 5;
  endfunction

  // Unit model: owns req_ready and the result pulse; checks request stability.
  always @(negedge clk) begin
    mul_resp_valid = 1'b0;
    if (rst_n) begin
      if (u_busy && cyc == u_due) begin
        mul_resp_valid = 1'b1;
        mul_resp_value = u_val;
        u_busy = 1'b0;
      end
      if (mul_req_valid) begin
        req_seen = 1'b1;
        chk("req_op", 64'(mul_op), 64'(cur_op));
        chk("req_word", 64'(mul_word), 64'(cur_word));
        chk("req_a", mul_a, cur_a);
        chk("req_b", mul_b, cur_b);
        if (stall_left > 0) begin
          mul_req_ready = 1'b0;
          stall_left--;
        end else begin
          mul_req_ready = 1'b1;
          u_busy = 1'b1;
          u_due = cyc + ulat(mul_op, mul_word);
          u_val = umodel(mul_op, mul_word, mul_a, mul_b);
        end
      end else begin
        mul_req_ready = 1'b0;
      end
    end
  end

  // Writeback monitor: owns wb_ready, pops the scoreboard on accept or flush.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wb_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_wb at cycle %0d: actual tag=%h value=%h required=no result",
                   cyc, wb_tag, wb_value);
          wb_ready = 1'b1;
        end else begin
          if (!prev_wbv) chk("wb_latency", 64'(cyc), 64'(sb[0].due));
          chk("wb_tag", 64'(wb_tag), 64'(sb[0].tag));
          chk("wb_rd", 64'(wb_rd), 64'(sb[0].rd));
          chk("wb_value", wb_value, sb[0].value);
          chk("iss_ready_in_done", 64'(iss_ready), 64'd0);
          if (hold_left > 0) begin
            wb_ready = 1'b0;
            hold_left--;
          end else begin
            wb_ready = 1'b1;
          end
          if (flush || wb_ready) begin
            void'(sb.pop_front());
            last_pop = cyc;
          end
        end
      end else begin
        wb_ready = 1'b0;
      end
      prev_wbv = wb_valid;
    end
  end

  task automatic drive_at(input int unsigned t);
    do begin @(posedge clk); #1; end while (cyc < t);
  endtask

  task automatic at_neg(input int unsigned t);
    do @(negedge clk); while (cyc < t);
  endtask

  task automatic issue(input mul_op_e op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [5:0] tag, input logic [4:0] rd,
                       input int unsigned stall, output int unsigned c);
    cur_op = op; cur_word = w; cur_a = a; cur_b = b;
    stall_left = stall;
    @(posedge clk); #1;
    iss_valid = 1'b1; iss_op = op; iss_word = w; iss_a = a; iss_b = b;
    iss_tag = tag; iss_rd = rd;
    @(negedge clk);
    c = cyc;
    chk("iss_ready_idle", 64'(iss_ready), 64'd1);
  endtask

  task automatic run_op(input mul_op_e op, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [5:0] tag, input logic [4:0] rd,
                        input int unsigned stall, input int unsigned hold,
                        input logic [63:0] exp_v, input int unsigned lat_off);
    int unsigned c;
    int i;
    hold_left = hold;
    issue(op, w, a, b, tag, rd, stall, c);
    sb.push_back('{tag, rd, exp_v, c + lat_off});
    @(posedge clk); #1;
    iss_valid = 1'b0;
    for (i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL wb_timeout tag=%h: actual=no writeback required=writeback", tag);
      sb.delete();
    end else begin
      while (cyc < last_pop + 1) @(negedge clk);
      chk("iss_ready_after_wb", 64'(iss_ready), 64'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int unsigned c;
    logic exp_req;
    // Reset values while reset is asserted.
    repeat (3) @(negedge clk);
    chk("rst_iss_ready", 64'(iss_ready), 64'd1);
    chk("rst_req_valid", 64'(mul_req_valid), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_value", wb_value, 64'd0);
    chk("rst_mul_a", mul_a, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed ops: op, word, a, b, tag, rd, req stall, wb hold, expected, wb latency.
    run_op(MUL_OP_MUL, 1'b0, 64'd3, 64'd5, 6'd7, 5'd10, 0, 0, 64'd15, 6);
    run_op(MUL_OP_MUL, 1'b1, 64'h7FFF_FFFF, 64'd2, 6'd1, 5'd2, 0, 0,
           64'hFFFF_FFFF_FFFF_FFFE, 4);
    run_op(MUL_OP_MULHU, 1'b0, '1, '1, 6'd2, 5'd3, 3, 0,
           64'hFFFF_FFFF_FFFF_FFFE, 10);
    run_op(MUL_OP_MUL, 1'b0, 64'h1234, 64'h10, 6'd3, 5'd1, 0, 4, 64'h12340, 6);
    run_op(MUL_OP_MULH, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 6'd4, 5'd5, 0, 0,
           64'hFFFF_FFFF_FFFF_FFFF, 7);
    run_op(MUL_OP_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'd5, 5'd6, 0, 0,
           64'hFFFF_FFFF_FFFF_FFFF, 7);

    // Flush in WAIT -> DRAIN; a second flush in DRAIN changes nothing.
    issue(MUL_OP_MUL, 1'b0, 64'd11, 64'd13, 6'd20, 5'd20, 0, c);
    drive_at(c + 1); iss_valid = 1'b0;
    drive_at(c + 2); flush = 1'b1;
    drive_at(c + 3); flush = 1'b0;
    at_neg(c + 3);
    chk("drain_iss_ready_a", 64'(iss_ready), 64'd0);
    drive_at(c + 4); flush = 1'b1;
    at_neg(c + 4);
    chk("drain_iss_ready_b", 64'(iss_ready), 64'd0);
    drive_at(c + 5); flush = 1'b0;
    at_neg(c + 5);
    chk("drain_iss_ready_c", 64'(iss_ready), 64'd0);
    at_neg(c + 6);
    chk("drain_exit_iss_ready", 64'(iss_ready), 64'd1);
    chk("drain_no_wb", 64'(wb_valid), 64'd0);
    run_op(MUL_OP_MUL, 1'b0, 64'd7, 64'd6, 6'd9, 5'd4, 0, 0, 64'd42, 6);

    // Flush in ISSUE while the unit stalls: the request is withdrawn.
    issue(MUL_OP_MULH, 1'b0, 64'd5, 64'd5, 6'd21, 5'd21, 5, c);
    drive_at(c + 1); iss_valid = 1'b0;
    drive_at(c + 2); flush = 1'b1;
    at_neg(c + 2);
    chk("flush_issue_req_valid", 64'(mul_req_valid), 64'd0);
    drive_at(c + 3); flush = 1'b0;
    stall_left = 0;
    at_neg(c + 3);
    chk("flush_issue_iss_ready", 64'(iss_ready), 64'd1);
    chk("flush_issue_req_after", 64'(mul_req_valid), 64'd0);

    // Flush in WAIT in the same cycle as the result pulse: straight to IDLE.
    issue(MUL_OP_MUL, 1'b1, 64'd3, 64'd3, 6'd22, 5'd22, 0, c);
    drive_at(c + 1); iss_valid = 1'b0;
    drive_at(c + 3); flush = 1'b1;
    drive_at(c + 4); flush = 1'b0;
    at_neg(c + 4);
    chk("flush_resp_iss_ready", 64'(iss_ready), 64'd1);
    chk("flush_resp_no_wb", 64'(wb_valid), 64'd0);

    // Flush in DONE with wb_ready high: the result is dropped, not written back.
    issue(MUL_OP_MUL, 1'b1, 64'd5, 64'd6, 6'd23, 5'd23, 0, c);
    sb.push_back('{6'd23, 5'd23, 64'd30, c + 4});
    drive_at(c + 1); iss_valid = 1'b0;
    drive_at(c + 4); flush = 1'b1;
    drive_at(c + 5); flush = 1'b0;
    at_neg(c + 5);
    chk("flush_done_wb_valid", 64'(wb_valid), 64'd0);
    chk("flush_done_iss_ready", 64'(iss_ready), 64'd1);
    chk("flush_done_sb_empty", 64'(sb.size()), 64'd0);
    sb.delete();

    // Zero operand: bypassed when the feature is built in, via the unit otherwise.
    req_seen = 1'b0;
`ifdef MUL_ZERO_BYPASS_EN
    exp_req = 1'b0;
    run_op(MUL_OP_MUL, 1'b0, 64'd0, 64'd9, 6'd30, 5'd30, 0, 0, 64'd0, 1);
`else
    exp_req = 1'b1;
    run_op(MUL_OP_MUL, 1'b0, 64'd0, 64'd9, 6'd30, 5'd30, 0, 0, 64'd0, 6);
`endif
    chk("zero_op_unit_used", 64'(req_seen), 64'(exp_req));
    run_op(MUL_OP_MUL, 1'b0, 64'd100, 64'd200, 6'd31, 5'd31, 0, 0, 64'd20000, 6);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
